// File: rtl/note_sched_pkg.sv
// Shared types and constants for the falling-note scheduler.
package note_sched_pkg;
   localparam int NSLOTS      = 64;
   localparam int IDX_W       = 6;
   localparam int N_W         = 6;
   localparam int COORD_W     = 10;
   localparam int STEP_W      = 4;
   localparam int CNT_W       = 7;
   localparam int Y_LIMIT_DEF = 480;

   // Matches the sprite-write register layout of the VGA peripheral.
   typedef struct packed {
      logic [IDX_W-1:0]   index;
      logic [N_W-1:0]     n;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } pkt_t;

   typedef enum logic [1:0] {INIT, IDLE, SWEEP} state_t;

   function automatic pkt_t mk_pkt(logic [IDX_W-1:0] index, logic [N_W-1:0] n,
                                   logic [COORD_W-1:0] y, logic [COORD_W-1:0] x);
      pkt_t p;
      p.index = index;
      p.n     = n;
      p.y     = y;
      p.x     = x;
      return p;
   endfunction
endpackage

// File: rtl/note_sched_if.sv
// Spawn/clear request channels and sprite-table write channel.
interface note_sched_if;
   import note_sched_pkg::*;
   logic               spawn_valid;
   logic               spawn_ready;
   logic [COORD_W-1:0] spawn_x;
   logic [N_W-1:0]     spawn_n;
   logic               clear_valid;
   logic               clear_ready;
   logic [IDX_W-1:0]   clear_index;
   logic               wr_valid;
   pkt_t               wr_data;

   modport master (output spawn_valid, spawn_x, spawn_n, clear_valid, clear_index,
                   input  spawn_ready, clear_ready, wr_valid, wr_data);
   modport slave  (input  spawn_valid, spawn_x, spawn_n, clear_valid, clear_index,
                   output spawn_ready, clear_ready, wr_valid, wr_data);
endinterface

// File: rtl/note_slot_alloc.sv
// Lowest-index free slot finder over the slot valid vector.
module note_slot_alloc
   import note_sched_pkg::*;
(
   input  logic [NSLOTS-1:0] valid,
   output logic [IDX_W-1:0]  free_index,
   output logic              full
);
   // Scan downward so the lowest free index is the last one written.
   always_comb begin
      free_index = '0;
      for (int i = NSLOTS-1; i >= 0; i--)
         if (!valid[i]) free_index = IDX_W'(i);
   end

   assign full = &valid;
endmodule

// File: rtl/note_sched.sv
// Falling-note scheduler owning the 64-entry sprite table.
// Define NOTE_SCHED_MISS_EN to add the saturating miss_count output.
module note_sched
   import note_sched_pkg::*;
#(
   parameter int Y_LIMIT = Y_LIMIT_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic [STEP_W-1:0] scroll_step,
   note_sched_if.slave       bus,
   output logic [CNT_W-1:0]  active_count,
   output logic              overflow
`ifdef NOTE_SCHED_MISS_EN
   ,
   output logic [15:0]       miss_count
`endif
);
   state_t              state;
   logic [IDX_W-1:0]    ptr;
   logic                pending;
   logic [STEP_W-1:0]   step;
   logic [NSLOTS-1:0]   valid;
   logic [COORD_W-1:0]  x_mem [NSLOTS];
   logic [COORD_W-1:0]  y_mem [NSLOTS];
   logic [N_W-1:0]      n_mem [NSLOTS];
   logic [IDX_W-1:0]    free_index;
   logic                full;
   logic                tick_evt, do_spawn, retire, sweep_upd, sweep_ret;
   logic [COORD_W:0]    sum;

   note_slot_alloc u_alloc (.valid(valid), .free_index(free_index), .full(full));

   assign tick_evt        = frame_tick | pending;
   assign bus.clear_ready = (state == IDLE) && !tick_evt;
   assign bus.spawn_ready = bus.clear_ready && !bus.clear_valid;
   assign do_spawn        = bus.spawn_ready && bus.spawn_valid && !full;

   // 11-bit sum so a y near the limit cannot wrap back on screen.
   assign sum       = {1'b0, y_mem[ptr]} + {{(COORD_W+1-STEP_W){1'b0}}, step};
   assign retire    = sum >= (COORD_W+1)'(Y_LIMIT);
   assign sweep_upd = (state == SWEEP) && valid[ptr] && !retire;
   assign sweep_ret = (state == SWEEP) && valid[ptr] && retire;

   always_ff @(posedge clk) begin
      if (do_spawn) begin
         x_mem[free_index] <= bus.spawn_x;
         y_mem[free_index] <= '0;
         n_mem[free_index] <= bus.spawn_n;
      end else if (sweep_upd) begin
         y_mem[ptr] <= sum[COORD_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= INIT;
         ptr          <= '0;
         pending      <= 1'b0;
         step         <= '0;
         valid        <= '0;
         bus.wr_valid <= 1'b0;
         bus.wr_data  <= '0;
         active_count <= '0;
         overflow     <= 1'b0;
      end else begin
         bus.wr_valid <= 1'b0;
         case (state)
            INIT: begin
               if (frame_tick) pending <= 1'b1;
               valid[ptr]   <= 1'b0;
               bus.wr_valid <= 1'b1;
               bus.wr_data  <= mk_pkt(ptr, '0, '0, '0);
               ptr          <= ptr + IDX_W'(1);
               if (ptr == IDX_W'(NSLOTS-1)) state <= IDLE;
            end
            IDLE: begin
               if (tick_evt) begin
                  step    <= scroll_step;
                  ptr     <= '0;
                  pending <= 1'b0;
                  state   <= SWEEP;
               end else if (bus.clear_valid) begin
                  if (valid[bus.clear_index]) begin
                     valid[bus.clear_index] <= 1'b0;
                     bus.wr_valid           <= 1'b1;
                     bus.wr_data            <= mk_pkt(bus.clear_index, '0, '0, '0);
                     active_count           <= active_count - CNT_W'(1);
                  end
               end else if (bus.spawn_valid) begin
                  if (full) begin
                     overflow <= 1'b1;
                  end else begin
                     valid[free_index] <= 1'b1;
                     bus.wr_valid      <= 1'b1;
                     bus.wr_data       <= mk_pkt(free_index, bus.spawn_n, '0, bus.spawn_x);
                     active_count      <= active_count + CNT_W'(1);
                  end
               end
            end
            SWEEP: begin
               if (frame_tick) pending <= 1'b1;
               if (sweep_ret) begin
                  valid[ptr]   <= 1'b0;
                  bus.wr_valid <= 1'b1;
                  bus.wr_data  <= mk_pkt(ptr, '0, '0, '0);
                  active_count <= active_count - CNT_W'(1);
               end else if (sweep_upd) begin
                  bus.wr_valid <= 1'b1;
                  bus.wr_data  <= mk_pkt(ptr, n_mem[ptr], sum[COORD_W-1:0], x_mem[ptr]);
               end
               ptr <= ptr + IDX_W'(1);
               if (ptr == IDX_W'(NSLOTS-1)) state <= IDLE;
            end
            default: state <= INIT;
         endcase
      end
   end

`ifdef NOTE_SCHED_MISS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         miss_count <= '0;
      else if (sweep_ret && miss_count != 16'hFFFF)
         miss_count <= miss_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_note_sched.sv
// Bench for note_sched: vector table for spawn/clear plus sweep, overflow and reset sequences.
module tb_note_sched;
   import note_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic [3:0]  scroll_step = '0;
   logic [6:0]  active_count;
   logic        overflow;
`ifdef NOTE_SCHED_MISS_EN
   logic [15:0] miss_count;
`endif

   note_sched_if bus();

   note_sched dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .scroll_step(scroll_step),
      .bus(bus), .active_count(active_count), .overflow(overflow)
`ifdef NOTE_SCHED_MISS_EN
      , .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   bit mv[64];
   int mx[64], my[64], mn[64];
   int mcount = 0;
   int mmiss  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int idx, input int n, input int y, input int x);
      return {6'(idx), 6'(n), 10'(y), 10'(x)};
   endfunction

   // Scoreboard: every packet on the write channel must match the next expectation.
   always @(negedge clk) begin
      if (bus.wr_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pkt: got %0h expected none", bus.wr_data);
         end else begin
            check("pkt", bus.wr_data, exp_q.pop_front());
         end
      end
   end

   task automatic sweep_expect(input int stp);
      for (int i = 0; i < 64; i++) begin
         if (mv[i]) begin
            int s;
            s = my[i] + stp;
            if (s >= 480) begin
               mv[i] = 1'b0;
               mcount--;
               mmiss++;
               exp_q.push_back(pk(i, 0, 0, 0));
            end else begin
               my[i] = s;
               exp_q.push_back(pk(i, mn[i], s, mx[i]));
            end
         end
      end
   endtask

   task automatic spawn_expect(input int x, input int n, output int slot);
      slot = -1;
      for (int i = 0; i < 64; i++)
         if (!mv[i]) begin slot = i; break; end
      if (slot >= 0) begin
         mv[slot] = 1'b1; mx[slot] = x; mn[slot] = n; my[slot] = 0;
         mcount++;
         exp_q.push_back(pk(slot, n, 0, x));
      end
   endtask

   // Entered just after a rising edge; one handshake cycle, returns just after the next edge.
   task automatic op(input bit is_clear, input int idx, input int x, input int n);
      if (is_clear) begin
         bus.clear_valid = 1'b1; bus.clear_index = 6'(idx);
      end else begin
         bus.spawn_valid = 1'b1; bus.spawn_x = 10'(x); bus.spawn_n = 6'(n);
      end
      #1;
      if (is_clear) check("clear_ready", {31'd0, bus.clear_ready}, 1);
      else          check("spawn_ready", {31'd0, bus.spawn_ready}, 1);
      @(posedge clk); #1;
      bus.clear_valid = 1'b0;
      bus.spawn_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      for (t = 0; t < 300; t++) begin
         if (bus.spawn_ready) break;
         @(posedge clk); #1;
      end
      check(name, {31'd0, t < 300}, 1);
   endtask

   task automatic frame(input int stp);
      scroll_step = 4'(stp);
      frame_tick  = 1'b1;
      sweep_expect(stp);
      @(posedge clk); #1;
      frame_tick = 1'b0;
      wait_idle("sweep_done");
   endtask

   task automatic init_replay();
      for (int i = 0; i < 64; i++) exp_q.push_back(pk(i, 0, 0, 0));
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk); #1;
         if (k == 63) check("init_ready_low", {31'd0, bus.spawn_ready}, 0);
         if (k == 64) check("init_ready_high", {31'd0, bus.spawn_ready}, 1);
      end
   endtask

   typedef struct {
      bit          is_clear;
      int          idx;
      int          x;
      int          n;
      bit          exp_wr;
      logic [31:0] exp_pkt;
      int          exp_cnt;
   } vec_t;

   vec_t vt[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int slot, cnt;
      vt[0] = '{0, 0, 100,  5, 1, pk(0,  5, 0, 100),  1};
      vt[1] = '{0, 0, 1023, 63, 1, pk(1, 63, 0, 1023), 2};
      vt[2] = '{0, 0, 0,    1, 1, pk(2,  1, 0, 0),    3};
      vt[3] = '{1, 1, 0,    0, 1, pk(1,  0, 0, 0),    2};
      vt[4] = '{1, 1, 0,    0, 0, 32'd0,              2};
      vt[5] = '{0, 0, 7,    9, 1, pk(1,  9, 0, 7),    3};
      vt[6] = '{1, 5, 0,    0, 0, 32'd0,              3};
      vt[7] = '{1, 0, 0,    0, 1, pk(0,  0, 0, 0),    2};
      vt[8] = '{1, 2, 0,    0, 1, pk(2,  0, 0, 0),    1};
      vt[9] = '{1, 1, 0,    0, 1, pk(1,  0, 0, 0),    0};

      bus.spawn_valid = 1'b0; bus.spawn_x = '0; bus.spawn_n = '0;
      bus.clear_valid = 1'b0; bus.clear_index = '0;

      // Reset values and INIT replay.
      #2;
      check("rst_wr_valid", {31'd0, bus.wr_valid}, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_spawn_ready", {31'd0, bus.spawn_ready}, 0);
      check("rst_clear_ready", {31'd0, bus.clear_ready}, 0);
      check("rst_count", {25'd0, active_count}, 0);
      check("rst_overflow", {31'd0, overflow}, 0);
      init_replay();

      // Vector table of spawn/clear requests.
      for (int i = 0; i < 10; i++) begin
         if (vt[i].exp_wr) exp_q.push_back(vt[i].exp_pkt);
         op(vt[i].is_clear, vt[i].idx, vt[i].x, vt[i].n);
         check($sformatf("vec%0d_wr_valid", i), {31'd0, bus.wr_valid}, {31'd0, vt[i].exp_wr});
         if (vt[i].exp_wr) check($sformatf("vec%0d_wr_data", i), bus.wr_data, vt[i].exp_pkt);
         check($sformatf("vec%0d_count", i), {25'd0, active_count}, 7'(vt[i].exp_cnt));
         if (vt[i].exp_wr) begin
            slot = int'(vt[i].exp_pkt[31:26]);
            mv[slot] = !vt[i].is_clear; mx[slot] = vt[i].x; mn[slot] = vt[i].n; my[slot] = 0;
         end
         mcount = vt[i].exp_cnt;
      end

      // One note falling to the bottom, with a zero-step frame first.
      spawn_expect(200, 3, slot);
      op(0, 0, 200, 3);
      frame(0);
      for (int f = 1; f <= 160; f++) frame(3);
      check("fall_count", {25'd0, active_count}, 7'(mcount));
      check("fall_count_zero", {25'd0, active_count}, 0);
`ifdef NOTE_SCHED_MISS_EN
      check("fall_miss", {16'd0, miss_count}, 32'(mmiss));
`endif

      // Fill the table, overflow on the 65th spawn, then reuse a cleared slot.
      for (int i = 0; i < 64; i++) begin
         spawn_expect(i * 16, (i % 63) + 1, slot);
         op(0, 0, i * 16, (i % 63) + 1);
      end
      check("fill_count", {25'd0, active_count}, 64);
      check("fill_overflow", {31'd0, overflow}, 0);
      spawn_expect(5, 5, slot);
      op(0, 0, 5, 5);
      check("ovf_no_pkt", {31'd0, bus.wr_valid}, 0);
      check("ovf_flag", {31'd0, overflow}, 1);
      mv[7] = 1'b0; mcount--;
      exp_q.push_back(pk(7, 0, 0, 0));
      op(1, 7, 0, 0);
      spawn_expect(77, 7, slot);
      op(0, 0, 77, 7);
      check("reuse_pkt", bus.wr_data, pk(7, 7, 0, 77));
      check("reuse_count", {25'd0, active_count}, 64);

      // Tick coincident with spawn, plus a second tick mid-sweep.
      scroll_step = 4'd1;
      frame_tick = 1'b1;
      bus.spawn_valid = 1'b1; bus.spawn_x = 10'd9; bus.spawn_n = 6'd9;
      sweep_expect(1);
      #1;
      check("tick_blocks_spawn", {31'd0, bus.spawn_ready}, 0);
      cnt = 1;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         frame_tick = (c == 10);
         if (c == 10) sweep_expect(1);
         #1;
         if (bus.spawn_ready) break;
         cnt++;
      end
      check("ready_low_cycles", cnt, 130);
      @(posedge clk); #1;
      bus.spawn_valid = 1'b0;
      spawn_expect(9, 9, slot);
      check("full_drop_no_pkt", {31'd0, bus.wr_valid}, 0);
      check("full_drop_count", {25'd0, active_count}, 64);

      // Reset while the sweep is visiting slot 30.
      frame_tick = 1'b1;
      for (int i = 0; i < 29; i++) exp_q.push_back(pk(i, mn[i], my[i] + 1, mx[i]));
      @(posedge clk); #1;
      frame_tick = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_wr_valid", {31'd0, bus.wr_valid}, 0);
      check("abort_wr_data", bus.wr_data, 0);
      check("abort_count", {25'd0, active_count}, 0);
      check("abort_overflow", {31'd0, overflow}, 0);
      check("abort_ready", {31'd0, bus.spawn_ready}, 0);
      check("abort_queue", exp_q.size(), 0);
`ifdef NOTE_SCHED_MISS_EN
      check("abort_miss", {16'd0, miss_count}, 0);
`endif
      for (int i = 0; i < 64; i++) mv[i] = 1'b0;
      mcount = 0; mmiss = 0;
      init_replay();

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
